gbc_memory_bus_router: RTL and testbench

- Parametrised successor of the GBC CPU memory bus decoder. Sits between the SM83 CPU port and the system targets: VRAM, WRAM, OAM, cartridge mapper and the IO register block.
- Adds a registered request/acknowledge transaction FSM, a per-transaction timeout and in-block HRAM.
- Owns the VRAM and WRAM bank registers (FF4F, FF70), with bank counts set by parameters.

---
 rtl/gbc_memory_bus_router.sv | 222 ++++++++++++++++++++++
 tb/tb_gbc_memory_bus_router.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbc_memory_bus_router.sv
// rtl/gbc_memory_bus_router.sv - SM83 CPU bus router with banking, HRAM and request/ack FSM
module gbc_memory_bus_router #(
  parameter  int VramBanks     = 2,
  parameter  int WramBanks     = 8,
  parameter  int HramDepth     = 127,
  parameter  int TimeoutCycles = 255,
  localparam int VaW           = 13 + $clog2(VramBanks),
  localparam int WaW           = 12 + $clog2(WramBanks)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           ClkEn,
  input  logic           IsCGB,
  input  logic           CpuAccess,
  input  logic           CpuWrite,
  input  logic [15:0]    CpuAddr,
  input  logic [7:0]     CpuWData,
  output logic           CpuReady,
  output logic [7:0]     CpuRData,
  output logic           CpuDataReady,
  output logic           TimeoutErr,
  output logic           VramReq,
  output logic           WramReq,
  output logic           OamReq,
  output logic           CartReq,
  output logic           IoReq,
  output logic           VramWrite,
  output logic           WramWrite,
  output logic           OamWrite,
  output logic           CartWrite,
  output logic           IoWrite,
  output logic [VaW-1:0] VramAddr,
  output logic [WaW-1:0] WramAddr,
  output logic [7:0]     OamAddr,
  output logic [15:0]    CartAddr,
  output logic [7:0]     IoAddr,
  output logic [7:0]     TgtWData,
  input  logic           VramAck,
  input  logic           WramAck,
  input  logic           OamAck,
  input  logic           CartAck,
  input  logic           IoAck,
  input  logic [7:0]     VramRData,
  input  logic [7:0]     WramRData,
  input  logic [7:0]     OamRData,
  input  logic [7:0]     CartRData,
  input  logic [7:0]     IoRData
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [3:0] {T_VRAM, T_WRAM, T_OAM, T_CART, T_IO,
                            T_HRAM, T_FF4F, T_FF70, T_NONE} tgt_t;

  localparam logic [2:0]  VMask   = 3'(VramBanks - 1);
  localparam logic [2:0]  WMask   = 3'(WramBanks - 1);
  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);

  state_t      r_state, w_next;
  tgt_t        r_tgt, w_dec_tgt;
  logic        r_write, r_timeout;
  logic [15:0] r_cnt;
  logic [7:0]  r_rdata;
  logic [2:0]  r_ff4f, r_ff70;
  logic [7:0]  r_hram [HramDepth];

  logic        w_dec_ext, w_ack, w_tmo;
  logic [7:0]  w_ack_data, w_int_rdata;
  logic [6:0]  w_hram_idx;
  logic [2:0]  w_wram_bank, w_vram_bank;
  logic [14:0] w_wram_full;
  logic [15:0] w_vram_full;

  assign w_hram_idx  = CpuAddr[6:0];
  // Echo space E000-FDFF only differs from C000-DDFF in bit 13, so bits 12:0 decode identically
  assign w_wram_bank = !CpuAddr[12] ? 3'd0 :
                       (((IsCGB && r_ff70 != 3'd0) ? r_ff70 : 3'd1) & WMask);
  assign w_vram_bank = IsCGB ? r_ff4f : 3'd0;
  assign w_wram_full = {w_wram_bank, CpuAddr[11:0]};
  assign w_vram_full = {w_vram_bank, CpuAddr[12:0]};
  assign w_dec_ext   = w_dec_tgt inside {T_VRAM, T_WRAM, T_OAM, T_CART, T_IO};
  assign w_tmo       = (r_cnt == TmoLast);

  assign CpuRData  = r_rdata;
  assign VramWrite = r_write;
  assign WramWrite = r_write;
  assign OamWrite  = r_write;
  assign CartWrite = r_write;
  assign IoWrite   = r_write;

  // Address decode of the live CPU address into a target
  always_comb begin
    w_dec_tgt = T_NONE;
    if (!CpuAddr[15] || CpuAddr[15:13] == 3'b101)        w_dec_tgt = T_CART;
    else if (CpuAddr[15:13] == 3'b100)                   w_dec_tgt = T_VRAM;
    else if (CpuAddr < 16'hFE00)                         w_dec_tgt = T_WRAM;
    else if (CpuAddr < 16'hFEA0)                         w_dec_tgt = T_OAM;
    else if (CpuAddr < 16'hFF00)                         w_dec_tgt = T_NONE;
    else if (CpuAddr == 16'hFF4F)                        w_dec_tgt = T_FF4F;
    else if (CpuAddr == 16'hFF70)                        w_dec_tgt = T_FF70;
    else if (CpuAddr < 16'hFF80 || CpuAddr == 16'hFFFF)  w_dec_tgt = T_IO;
    else if (int'(w_hram_idx) < HramDepth)               w_dec_tgt = T_HRAM;
  end

  // Read data for accesses answered inside the router
  always_comb begin
    w_int_rdata = 8'hFF;
    case (w_dec_tgt)
      T_HRAM:  w_int_rdata = r_hram[w_hram_idx];
      T_FF4F:  w_int_rdata = ~{5'd0, VMask} | {5'd0, r_ff4f};
      T_FF70:  w_int_rdata = {5'b11111, r_ff70};
      default: w_int_rdata = 8'hFF;
    endcase
  end

  // Acknowledge and read data from the target owning the current transaction
  always_comb begin
    w_ack      = 1'b0;
    w_ack_data = 8'hFF;
    case (r_tgt)
      T_VRAM:  begin w_ack = VramAck; w_ack_data = VramRData; end
      T_WRAM:  begin w_ack = WramAck; w_ack_data = WramRData; end
      T_OAM:   begin w_ack = OamAck;  w_ack_data = OamRData;  end
      T_CART:  begin w_ack = CartAck; w_ack_data = CartRData; end
      T_IO:    begin w_ack = IoAck;   w_ack_data = IoRData;   end
      default: begin w_ack = 1'b0;    w_ack_data = 8'hFF;     end
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)   r_state <= S_IDLE;
    else if (ClkEn) r_state <= w_next;
  end

  // FSM next state and handshake outputs; Req is a pure function of state so reset drops it at once
  always_comb begin
    w_next       = r_state;
    CpuReady     = 1'b0;
    CpuDataReady = 1'b0;
    TimeoutErr   = 1'b0;
    VramReq      = 1'b0;
    WramReq      = 1'b0;
    OamReq       = 1'b0;
    CartReq      = 1'b0;
    IoReq        = 1'b0;
    case (r_state)
      S_IDLE: begin
        CpuReady = 1'b1;
        if (ClkEn && CpuAccess) w_next = w_dec_ext ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        VramReq = (r_tgt == T_VRAM);
        WramReq = (r_tgt == T_WRAM);
        OamReq  = (r_tgt == T_OAM);
        CartReq = (r_tgt == T_CART);
        IoReq   = (r_tgt == T_IO);
        if (ClkEn && (w_ack || w_tmo)) w_next = S_RESP;
      end
      S_RESP: begin
        CpuDataReady = 1'b1;
        TimeoutErr   = r_timeout;
        if (ClkEn) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction latches, bank registers, wait counter and response data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tgt     <= T_NONE;
      r_write   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= 16'd0;
      r_rdata   <= 8'd0;
      r_ff4f    <= 3'd0;
      r_ff70    <= 3'd0;
      VramAddr  <= '0;
      WramAddr  <= '0;
      OamAddr   <= 8'd0;
      CartAddr  <= 16'd0;
      IoAddr    <= 8'd0;
      TgtWData  <= 8'd0;
    end else if (ClkEn) begin
      case (r_state)
        S_IDLE: if (CpuAccess) begin
          r_tgt     <= w_dec_tgt;
          r_write   <= CpuWrite;
          r_timeout <= 1'b0;
          r_cnt     <= 16'd0;
          r_rdata   <= w_int_rdata;
          VramAddr  <= w_vram_full[VaW-1:0];
          WramAddr  <= w_wram_full[WaW-1:0];
          OamAddr   <= CpuAddr[7:0];
          CartAddr  <= CpuAddr;
          IoAddr    <= CpuAddr[7:0];
          TgtWData  <= CpuWData;
          if (CpuWrite && w_dec_tgt == T_FF4F) r_ff4f <= CpuWData[2:0] & VMask;
          if (CpuWrite && w_dec_tgt == T_FF70) r_ff70 <= CpuWData[2:0];
        end
        S_WAIT: begin
          if (w_ack) begin
            r_rdata <= w_ack_data;
          end else if (w_tmo) begin
            r_rdata   <= 8'hFF;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // HRAM storage, intentionally left uninitialised by reset
  always_ff @(posedge Clk) begin
    if (Reset_n && ClkEn && r_state == S_IDLE && CpuAccess && CpuWrite && w_dec_tgt == T_HRAM)
      r_hram[w_hram_idx] <= CpuWData;
  end

endmodule

// File: tb/tb_gbc_memory_bus_router.sv
// tb/tb_gbc_memory_bus_router.sv - scoreboard testbench for gbc_memory_bus_router
module tb_gbc_memory_bus_router;

  logic        Clk = 1'b0;
  logic        Reset_n, ClkEn, IsCGB, CpuAccess, CpuWrite;
  logic [15:0] CpuAddr;
  logic [7:0]  CpuWData;
  logic        CpuReady, CpuDataReady, TimeoutErr;
  logic [7:0]  CpuRData;
  logic        VramReq, WramReq, OamReq, CartReq, IoReq;
  logic        VramWrite, WramWrite, OamWrite, CartWrite, IoWrite;
  logic [13:0] VramAddr;
  logic [14:0] WramAddr;
  logic [7:0]  OamAddr, IoAddr, TgtWData;
  logic [15:0] CartAddr;
  logic [4:0]  ack;
  logic [7:0]  rd [5];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       chk;
    logic [7:0] rdata;
    logic       tmo;
  } exp_t;
  exp_t sbq[$];

  wire [4:0] reqs = {IoReq, CartReq, OamReq, WramReq, VramReq};

  gbc_memory_bus_router #(
    .VramBanks(2), .WramBanks(8), .HramDepth(127), .TimeoutCycles(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .IsCGB(IsCGB),
    .CpuAccess(CpuAccess), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuReady(CpuReady), .CpuRData(CpuRData), .CpuDataReady(CpuDataReady), .TimeoutErr(TimeoutErr),
    .VramReq(VramReq), .WramReq(WramReq), .OamReq(OamReq), .CartReq(CartReq), .IoReq(IoReq),
    .VramWrite(VramWrite), .WramWrite(WramWrite), .OamWrite(OamWrite), .CartWrite(CartWrite),
    .IoWrite(IoWrite),
    .VramAddr(VramAddr), .WramAddr(WramAddr), .OamAddr(OamAddr), .CartAddr(CartAddr),
    .IoAddr(IoAddr), .TgtWData(TgtWData),
    .VramAck(ack[0]), .WramAck(ack[1]), .OamAck(ack[2]), .CartAck(ack[3]), .IoAck(ack[4]),
    .VramRData(rd[0]), .WramRData(rd[1]), .OamRData(rd[2]), .CartRData(rd[3]), .IoRData(rd[4])
  );

  always #5 Clk = ~Clk;

  // Scoreboard: every completion pulse pops one expected response
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && ClkEn && CpuDataReady) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_dataready got=1 want=0 at %0t", $time);
      end else begin
        e = sbq.pop_front();
        if (e.chk) begin
          total++;
          if (CpuRData !== e.rdata) begin
            bad++;
            $display("FAIL rdata got=%02h want=%02h at %0t", CpuRData, e.rdata, $time);
          end
        end
        total++;
        if (TimeoutErr !== e.tmo) begin
          bad++;
          $display("FAIL timeout_err got=%b want=%b at %0t", TimeoutErr, e.tmo, $time);
        end
      end
    end
    if ($countones(reqs) > 1) begin
      total++; bad++;
      $display("FAIL req_onehot got=%b at %0t", reqs, $time);
    end
  end

  task automatic idle_wait();
    for (int i = 0; i < 20; i++) begin
      if (CpuReady === 1'b1) return;
      @(posedge Clk); #1;
    end
    total++; bad++;
    $display("FAIL idle_timeout got=busy want=idle");
  endtask

  task automatic int_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                            input logic [7:0] exp_rd);
    exp_t e;
    e.chk = !w; e.rdata = exp_rd; e.tmo = 1'b0;
    sbq.push_back(e);
    CpuAccess = 1'b1; CpuWrite = w; CpuAddr = a; CpuWData = d;
    @(posedge Clk); #1;
    CpuAccess = 1'b0;
    total++;
    if (CpuDataReady !== 1'b1 || reqs !== 5'd0) begin
      bad++;
      $display("FAIL int_latency addr=%04h got dr=%b req=%b want dr=1 req=0", a, CpuDataReady, reqs);
    end
    @(posedge Clk); #1;
    idle_wait();
  endtask

  task automatic ext_read(input logic [15:0] a, input int tgt, input int ack_after,
                          input logic [7:0] rv, input logic [15:0] exp_addr);
    exp_t e;
    int held;
    logic [15:0] got_addr;
    e.chk = 1'b1; e.rdata = (ack_after > 0) ? rv : 8'hFF; e.tmo = (ack_after == 0);
    sbq.push_back(e);
    CpuAccess = 1'b1; CpuWrite = 1'b0; CpuAddr = a; CpuWData = 8'h00;
    @(posedge Clk); #1;
    CpuAccess = 1'b0;
    case (tgt)
      0:       got_addr = 16'(VramAddr);
      1:       got_addr = 16'(WramAddr);
      2:       got_addr = 16'(OamAddr);
      3:       got_addr = CartAddr;
      default: got_addr = 16'(IoAddr);
    endcase
    total++;
    if (reqs !== 5'(1 << tgt)) begin
      bad++;
      $display("FAIL req_select addr=%04h got=%b want=%b", a, reqs, 5'(1 << tgt));
    end
    total++;
    if (got_addr !== exp_addr) begin
      bad++;
      $display("FAIL tgt_addr addr=%04h got=%04h want=%04h", a, got_addr, exp_addr);
    end
    held = 0;
    for (int c = 1; c <= 20; c++) begin
      if (reqs === 5'd0) break;
      held++;
      if (c == ack_after) begin ack[tgt] = 1'b1; rd[tgt] = rv; end
      @(posedge Clk); #1;
      ack = '0;
    end
    total++;
    if (held != ((ack_after > 0) ? ack_after : 4)) begin
      bad++;
      $display("FAIL req_held addr=%04h got=%0d want=%0d", a, held, (ack_after > 0) ? ack_after : 4);
    end
    total++;
    if (CpuDataReady !== 1'b1) begin
      bad++;
      $display("FAIL ext_latency addr=%04h got=%b want=1", a, CpuDataReady);
    end
    @(posedge Clk); #1;
    idle_wait();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; ClkEn = 1'b1; IsCGB = 1'b1; CpuAccess = 1'b0; CpuWrite = 1'b0;
    CpuAddr = 16'h0000; CpuWData = 8'h00; ack = '0;
    for (int i = 0; i < 5; i++) rd[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (CpuReady !== 1'b1 || CpuDataReady !== 1'b0 || TimeoutErr !== 1'b0 || reqs !== 5'd0) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b dr=%b to=%b req=%b want 1 0 0 00000",
               CpuReady, CpuDataReady, TimeoutErr, reqs);
    end
    total++;
    if (CpuRData !== 8'h00 || VramAddr !== 14'd0 || CartAddr !== 16'd0 || TgtWData !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got rd=%02h va=%04h ca=%04h wd=%02h want zeros",
               CpuRData, VramAddr, CartAddr, TgtWData);
    end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_hram();
    int_access(16'hFF85, 1'b1, 8'h5A, 8'h00);
    int_access(16'hFF85, 1'b0, 8'h00, 8'h5A);
    int_access(16'hFFFE, 1'b1, 8'hA7, 8'h00);
    int_access(16'hFFFE, 1'b0, 8'h00, 8'hA7);
    int_access(16'hFF85, 1'b0, 8'h00, 8'h5A);
  endtask

  task automatic test_wram_bank();
    IsCGB = 1'b1;
    int_access(16'hFF70, 1'b1, 8'h00, 8'h00);
    ext_read(16'hD123, 1, 2, 8'h11, 16'h1123);
    int_access(16'hFF70, 1'b1, 8'h05, 8'h00);
    ext_read(16'hD123, 1, 1, 8'h22, 16'h5123);
    int_access(16'hFF70, 1'b0, 8'h00, 8'hFD);
    ext_read(16'hC456, 1, 1, 8'h23, 16'h0456);
    IsCGB = 1'b0;
    ext_read(16'hD123, 1, 1, 8'h33, 16'h1123);
    int_access(16'hFF70, 1'b0, 8'h00, 8'hFD);
    IsCGB = 1'b1;
  endtask

  task automatic test_echo_unmapped();
    ext_read(16'hE010, 1, 1, 8'h44, 16'h0010);
    int_access(16'hFEB0, 1'b0, 8'h00, 8'hFF);
    int_access(16'hFEB0, 1'b1, 8'h12, 8'h00);
    ext_read(16'hFE10, 2, 2, 8'h55, 16'h0010);
  endtask

  task automatic test_vram_bank();
    int_access(16'hFF4F, 1'b1, 8'h01, 8'h00);
    int_access(16'hFF4F, 1'b0, 8'h00, 8'hFF);
    ext_read(16'h8123, 0, 2, 8'h66, 16'h2123);
    IsCGB = 1'b0;
    ext_read(16'h8123, 0, 1, 8'h67, 16'h0123);
    IsCGB = 1'b1;
    int_access(16'hFF4F, 1'b1, 8'h00, 8'h00);
    int_access(16'hFF4F, 1'b0, 8'h00, 8'hFE);
  endtask

  task automatic test_cart();
    ext_read(16'h4567, 3, 3, 8'h3C, 16'h4567);
    ext_read(16'hA001, 3, 1, 8'hC3, 16'hA001);
  endtask

  task automatic test_timeout();
    ext_read(16'hFF40, 4, 0, 8'h00, 16'h0040);
    ext_read(16'hFFFF, 4, 4, 8'h81, 16'h00FF);
  endtask

  task automatic test_reset_in_wait();
    int_access(16'hFF4F, 1'b1, 8'h01, 8'h00);
    CpuAccess = 1'b1; CpuWrite = 1'b0; CpuAddr = 16'h9000;
    @(posedge Clk); #1;
    CpuAccess = 1'b0;
    total++;
    if (VramReq !== 1'b1) begin
      bad++;
      $display("FAIL vram_req_before_reset got=%b want=1", VramReq);
    end
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if (VramReq !== 1'b0 || CpuReady !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got req=%b rdy=%b want req=0 rdy=1", VramReq, CpuReady);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    ack[0] = 1'b1; rd[0] = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      total++;
      if (CpuDataReady !== 1'b0 || reqs !== 5'd0) begin
        bad++;
        $display("FAIL stale_ack got dr=%b req=%b want dr=0 req=0", CpuDataReady, reqs);
      end
    end
    ack = '0;
    int_access(16'hFF4F, 1'b0, 8'h00, 8'hFE);
  endtask

  initial begin
    test_reset();
    test_hram();
    test_wram_bank();
    test_echo_unmapped();
    test_vram_bank();
    test_cart();
    test_timeout();
    test_reset_in_wait();
    repeat (2) @(posedge Clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
